param_reg_file: RTL and testbench

PARAM_REG_FILE -- requirements
Module: param_reg_file

---
 rtl/param_reg_file.sv | 83 ++++++++
 tb/tb_param_reg_file.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_reg_file.sv
// Parameterised register file with a per-register busy scoreboard.
// It supports an optional hardwired-zero register 0 and optional same-cycle write forwarding.
module param_reg_file #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    input  logic [ADDR_W-1:0] DstReg,
    input  logic              WriteReg,
    input  logic [DATA_W-1:0] DstData,
    input  logic [ADDR_W-1:0] ResvReg,
    input  logic              ResvEn,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2,
    output logic              Busy1,
    output logic              Busy2,
    output logic              BusyResv,
    output logic              Hazard
);

    localparam bit ZeroEn = (ZERO_REG != 0);
    localparam bit BypEn  = (BYPASS != 0);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;

    // The release is applied before the reservation so that a new producer
    // reserving the register being written back leaves it busy.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (WriteReg) begin
            if (!(ZeroEn && DstReg == '0)) begin
                regs_d[DstReg] = DstData;
            end
            busy_d[DstReg] = 1'b0;
        end
        if (ResvEn && !(ZeroEn && ResvReg == '0)) begin
            busy_d[ResvReg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    logic zero1, zero2, zeroR;
    logic hit1, hit2, hitR;
    logic [DATA_W-1:0] wrData;

    always_comb begin
        zero1  = ZeroEn && (SrcReg1 == '0);
        zero2  = ZeroEn && (SrcReg2 == '0);
        zeroR  = ZeroEn && (ResvReg == '0);
        hit1   = BypEn && WriteReg && (DstReg == SrcReg1);
        hit2   = BypEn && WriteReg && (DstReg == SrcReg2);
        hitR   = BypEn && WriteReg && (DstReg == ResvReg);
        wrData = (ZeroEn && DstReg == '0) ? '0 : DstData;
    end

    // A forwarded write means the pending producer is completing right now.
    always_comb begin
        SrcData1 = zero1 ? '0 : (hit1 ? wrData : regs_q[SrcReg1]);
        SrcData2 = zero2 ? '0 : (hit2 ? wrData : regs_q[SrcReg2]);
        Busy1    = !zero1 && !hit1 && busy_q[SrcReg1];
        Busy2    = !zero2 && !hit2 && busy_q[SrcReg2];
        BusyResv = !zeroR && !hitR && busy_q[ResvReg];
        Hazard   = Busy1 | Busy2 | (ResvEn & BusyResv);
    end

endmodule

// File: tb/tb_param_reg_file.sv
// Checks three param_reg_file configurations (default, no bypass, 32-bit without zero register)
// against a directed vector table and an array-based reference model.
module tb_param_reg_file;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  dst;
        logic [31:0] data;
        logic        resvEn;
        logic [4:0]  resv;
        logic [4:0]  src1;
        logic [4:0]  src2;
    } stim_t;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
        logic        br;
        logic        hz;
    } out_t;

    typedef struct {
        stim_t s;
        out_t  e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, we, resvEn;
    logic [4:0]  dst, resv, src1, src2;
    logic [31:0] data;
    stim_t       cur;

    logic [15:0] aD1, aD2, bD1, bD2;
    logic [31:0] cD1, cD2;
    logic aB1, aB2, aBr, aHz, bB1, bB2, bBr, bHz, cB1, cB2, cBr, cHz;

    int errors = 0;
    int checks = 0;

    param_reg_file #(.DATA_W(16), .NUM_REGS(16), .ZERO_REG(1), .BYPASS(1)) dutA (
        .clk(clk), .rst(rst), .SrcReg1(src1[3:0]), .SrcReg2(src2[3:0]), .DstReg(dst[3:0]),
        .WriteReg(we), .DstData(data[15:0]), .ResvReg(resv[3:0]), .ResvEn(resvEn),
        .SrcData1(aD1), .SrcData2(aD2), .Busy1(aB1), .Busy2(aB2), .BusyResv(aBr), .Hazard(aHz));

    param_reg_file #(.DATA_W(16), .NUM_REGS(16), .ZERO_REG(1), .BYPASS(0)) dutB (
        .clk(clk), .rst(rst), .SrcReg1(src1[3:0]), .SrcReg2(src2[3:0]), .DstReg(dst[3:0]),
        .WriteReg(we), .DstData(data[15:0]), .ResvReg(resv[3:0]), .ResvEn(resvEn),
        .SrcData1(bD1), .SrcData2(bD2), .Busy1(bB1), .Busy2(bB2), .BusyResv(bBr), .Hazard(bHz));

    param_reg_file #(.DATA_W(32), .NUM_REGS(32), .ZERO_REG(0), .BYPASS(1)) dutC (
        .clk(clk), .rst(rst), .SrcReg1(src1), .SrcReg2(src2), .DstReg(dst),
        .WriteReg(we), .DstData(data), .ResvReg(resv), .ResvEn(resvEn),
        .SrcData1(cD1), .SrcData2(cD2), .Busy1(cB1), .Busy2(cB2), .BusyResv(cBr), .Hazard(cHz));

    // Reference model: one register array and busy array per configuration
    logic [31:0] mReg[3][32];
    bit          mBusy[3][32];
    bit          cfgZero[3] = '{1'b1, 1'b1, 1'b0};
    bit          cfgByp[3]  = '{1'b1, 1'b0, 1'b1};

    function automatic logic [31:0] dataMask(int k);
        return (k == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic int addrMask(int k);
        return (k == 2) ? 31 : 15;
    endfunction

    function automatic void modelReset();
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 32; r++) begin
                mReg[k][r]  = '0;
                mBusy[k][r] = 1'b0;
            end
    endfunction

    function automatic void modelUpdate(stim_t s);
        if (s.rst) begin
            modelReset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            int d = int'(s.dst) & addrMask(k);
            int r = int'(s.resv) & addrMask(k);
            if (s.we) begin
                if (!(cfgZero[k] && d == 0)) mReg[k][d] = s.data & dataMask(k);
                mBusy[k][d] = 1'b0;
            end
            if (s.resvEn && !(cfgZero[k] && r == 0)) mBusy[k][r] = 1'b1;
        end
    endfunction

    function automatic logic [31:0] modelRead(int k, stim_t s, int a);
        int d = int'(s.dst) & addrMask(k);
        if (cfgZero[k] && a == 0) return '0;
        if (cfgByp[k] && s.we && d == a) return s.data & dataMask(k);
        return mReg[k][a];
    endfunction

    function automatic logic modelBusy(int k, stim_t s, int a);
        int d = int'(s.dst) & addrMask(k);
        if (cfgZero[k] && a == 0) return 1'b0;
        if (cfgByp[k] && s.we && d == a) return 1'b0;
        return mBusy[k][a];
    endfunction

    function automatic out_t modelOut(int k, stim_t s);
        out_t o;
        int a1 = int'(s.src1) & addrMask(k);
        int a2 = int'(s.src2) & addrMask(k);
        int ar = int'(s.resv) & addrMask(k);
        o.d1 = modelRead(k, s, a1);
        o.d2 = modelRead(k, s, a2);
        o.b1 = modelBusy(k, s, a1);
        o.b2 = modelBusy(k, s, a2);
        o.br = modelBusy(k, s, ar);
        o.hz = o.b1 | o.b2 | (s.resvEn & o.br);
        return o;
    endfunction

    function automatic out_t getActual(int k);
        out_t o;
        case (k)
            0:       o = '{{16'h0, aD1}, {16'h0, aD2}, aB1, aB2, aBr, aHz};
            1:       o = '{{16'h0, bD1}, {16'h0, bD2}, bB1, bB2, bBr, bHz};
            default: o = '{cD1, cD2, cB1, cB2, cBr, cHz};
        endcase
        return o;
    endfunction

    function automatic stim_t mkStim(logic r, logic w, int d, logic [31:0] dat,
                                     logic re, int rv, int s1, int s2);
        stim_t s;
        s.rst = r; s.we = w; s.dst = 5'(d); s.data = dat;
        s.resvEn = re; s.resv = 5'(rv); s.src1 = 5'(s1); s.src2 = 5'(s2);
        return s;
    endfunction

    function automatic out_t mkOut(logic [15:0] d1, logic [15:0] d2,
                                   logic b1, logic b2, logic br, logic hz);
        return '{{16'h0, d1}, {16'h0, d2}, b1, b2, br, hz};
    endfunction

    task automatic applyStimulus(stim_t s);
        cur    = s;
        rst    = s.rst;
        we     = s.we;
        dst    = s.dst;
        data   = s.data;
        resvEn = s.resvEn;
        resv   = s.resv;
        src1   = s.src1;
        src2   = s.src2;
    endtask

    task automatic checkOutput(string name, logic [67:0] act, logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkModel(string tag);
        for (int k = 0; k < 3; k++)
            checkOutput($sformatf("%s dut%0d", tag, k), 68'(getActual(k)), 68'(modelOut(k, cur)));
    endtask

    task automatic stepEdge();
        @(posedge clk);
        modelUpdate(cur);
        #1;
    endtask

    task automatic runModelCycle(stim_t s, string tag);
        applyStimulus(s);
        @(negedge clk);
        checkModel(tag);
        stepEdge();
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{mkStim(0,0, 0,32'h0000,0,0,0,0), mkOut(16'h0000,16'h0000,0,0,0,0)};
        vecs[1]  = '{mkStim(0,1, 3,32'hBEEF,0,0,3,0), mkOut(16'hBEEF,16'h0000,0,0,0,0)};
        vecs[2]  = '{mkStim(0,1, 0,32'h1234,0,0,3,0), mkOut(16'hBEEF,16'h0000,0,0,0,0)};
        vecs[3]  = '{mkStim(0,0, 0,32'h0000,0,0,0,3), mkOut(16'h0000,16'hBEEF,0,0,0,0)};
        vecs[4]  = '{mkStim(0,1, 5,32'hA5A5,0,0,3,5), mkOut(16'hBEEF,16'hA5A5,0,0,0,0)};
        vecs[5]  = '{mkStim(0,0, 0,32'h0000,1,7,7,5), mkOut(16'h0000,16'hA5A5,0,0,0,0)};
        vecs[6]  = '{mkStim(0,0, 0,32'h0000,0,7,7,7), mkOut(16'h0000,16'h0000,1,1,1,1)};
        vecs[7]  = '{mkStim(0,1, 7,32'h1111,0,7,7,3), mkOut(16'h1111,16'hBEEF,0,0,0,0)};
        vecs[8]  = '{mkStim(0,0, 0,32'h0000,0,7,7,0), mkOut(16'h1111,16'h0000,0,0,0,0)};
        vecs[9]  = '{mkStim(0,0, 0,32'h0000,1,9,9,0), mkOut(16'h0000,16'h0000,0,0,0,0)};
        vecs[10] = '{mkStim(0,1, 9,32'h2222,1,9,9,9), mkOut(16'h2222,16'h2222,0,0,0,0)};
        vecs[11] = '{mkStim(0,0, 0,32'h0000,0,9,9,9), mkOut(16'h2222,16'h2222,1,1,1,1)};
        vecs[12] = '{mkStim(0,0, 0,32'h0000,1,0,0,9), mkOut(16'h0000,16'h2222,0,1,0,1)};
        vecs[13] = '{mkStim(0,0, 0,32'h0000,0,0,0,4), mkOut(16'h0000,16'h0000,0,0,0,0)};
        vecs[14] = '{mkStim(0,0, 0,32'h0000,1,9,0,0), mkOut(16'h0000,16'h0000,0,0,1,1)};

        modelReset();
        @(posedge clk);
        #1;
        applyStimulus(mkStim(1,0,0,0,0,0,0,0));
        stepEdge();

        // Directed table: configuration A against hand-derived values, others against the model
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].s);
            @(negedge clk);
            checkOutput($sformatf("vec%0d dutA", i), 68'(getActual(0)), 68'(vecs[i].e));
            checkOutput($sformatf("vec%0d dutB", i), 68'(getActual(1)), 68'(modelOut(1, cur)));
            checkOutput($sformatf("vec%0d dutC", i), 68'(getActual(2)), 68'(modelOut(2, cur)));
            stepEdge();
        end

        // Without forwarding the old value is seen until the following cycle
        applyStimulus(mkStim(0,1,5,32'h0000_5A5A,0,1,1,5));
        @(negedge clk);
        checkOutput("nobypass old", 68'(bD2), 68'h A5A5);
        checkOutput("bypass new", 68'(aD2), 68'h 5A5A);
        stepEdge();
        applyStimulus(mkStim(0,0,0,0,0,1,1,5));
        @(negedge clk);
        checkOutput("nobypass next", 68'(bD2), 68'h 5A5A);
        stepEdge();

        // Register 0 is an ordinary register when the zero register is disabled
        runModelCycle(mkStim(0,1,0,32'hDEAD_BEEF,0,1,1,2), "c r0 write");
        applyStimulus(mkStim(0,0,0,0,1,0,0,0));
        @(negedge clk);
        checkOutput("c r0 read", 68'(cD1), 68'h DEAD_BEEF);
        checkOutput("a r0 read", 68'(aD1), 68'h0);
        stepEdge();
        applyStimulus(mkStim(0,0,0,0,0,0,0,0));
        @(negedge clk);
        checkOutput("c r0 busy", 68'(cB1), 68'h1);
        checkOutput("a r0 busy", 68'(aB1), 68'h0);
        stepEdge();

        // Reset with outstanding reservations, while a write and reserve are also requested
        for (int r = 1; r < 16; r++)
            runModelCycle(mkStim(0,1,r,32'h1111 * r,0,1,r,16-r), "load");
        runModelCycle(mkStim(0,0,0,0,1,2,2,4), "resv2");
        runModelCycle(mkStim(0,0,0,0,1,4,2,4), "resv4");
        applyStimulus(mkStim(1,1,6,32'hFFFF,1,6,2,4));
        @(negedge clk);
        checkOutput("pre-reset busy", 68'({aB1, aB2}), 68'b11);
        stepEdge();
        for (int r = 0; r < 16; r++) begin
            applyStimulus(mkStim(0,0,0,0,0,r,r,15-r));
            @(negedge clk);
            checkOutput($sformatf("post-reset r%0d", r), 68'(getActual(0)), 68'(out_t'('0)));
            checkModel("post-reset");
            stepEdge();
        end
        applyStimulus(mkStim(0,0,0,0,1,2,0,0));
        @(negedge clk);
        checkOutput("resv2 before", 68'(aBr), 68'h0);
        stepEdge();
        applyStimulus(mkStim(0,1,4,32'h4444,0,2,4,2));
        @(negedge clk);
        checkOutput("resv2 after", 68'({aBr, aB2, aHz}), 68'b111);
        checkOutput("r4 released", 68'(aB1), 68'h0);
        stepEdge();
        applyStimulus(mkStim(0,0,0,0,0,4,4,2));
        @(negedge clk);
        checkOutput("r4 written", 68'({aD1, aB1}), 68'({16'h4444, 1'b0}));
        checkModel("r4 after");
        stepEdge();

        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            stim_t s;
            s.rst    = ($urandom_range(0, 39) == 0);
            s.we     = $urandom_range(0, 1) == 1;
            s.dst    = 5'($urandom_range(0, 31));
            s.data   = $urandom;
            s.resvEn = $urandom_range(0, 1) == 1;
            s.resv   = ($urandom_range(0, 3) == 0) ? s.dst : 5'($urandom_range(0, 31));
            s.src1   = ($urandom_range(0, 3) == 0) ? s.dst : 5'($urandom_range(0, 31));
            s.src2   = ($urandom_range(0, 3) == 0) ? s.src1 : 5'($urandom_range(0, 31));
            runModelCycle(s, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
